// File: rtl/dm_pkg.sv
// Shared encodings for the byte-addressed data memory.
//   SZ_*      : access size field values
//   dm_state_e: init sweep / running states
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } dm_state_e;

endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane logic for dm_bytemem.
// Ports:
//   req_size, req_off, req_wdata   : request-time size, addr[1:0], store data
//   req_be, req_wdata_rep          : byte enables and lane-replicated store data
//   req_misalign                   : misaligned access or reserved size
//   ld_size, ld_off, ld_uns, ld_word : registered load attributes and raw word
//   ld_data                        : lane-selected, extended load result
module dm_lane
  import dm_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic [1:0]  req_size,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  output logic [31:0] req_wdata_rep,
  output logic        req_misalign,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  // Physical byte lane: big-endian mirrors the offset (lane = 3 - off).
  logic [1:0] req_lane;
  logic       req_half_hi;
  logic [1:0] ld_lane;
  logic       ld_half_hi;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req_lane    = (BIG_ENDIAN != 0) ? ~req_off : req_off;
    req_half_hi = (BIG_ENDIAN != 0) ? ~req_off[1] : req_off[1];

    req_misalign = (req_size == 2'b11) ||
                   ((req_size == SZ_H) && req_off[0]) ||
                   ((req_size == SZ_W) && (req_off != 2'b00));

    req_be        = 4'b0000;
    req_wdata_rep = req_wdata;
    case (req_size)
      SZ_B: begin
        req_be        = 4'b0001 << req_lane;
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        req_be        = req_half_hi ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      SZ_W: req_be = 4'b1111;
      default: req_be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_lane    = (BIG_ENDIAN != 0) ? ~ld_off : ld_off;
    ld_half_hi = (BIG_ENDIAN != 0) ? ~ld_off[1] : ld_off[1];

    case (ld_lane)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = ld_half_hi ? ld_word[31:16] : ld_word[15:0];

    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~ld_uns & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dm_bytemem.sv
// Byte-addressed data memory for the MEM stage, with post-reset clear sweep.
// Ports:
//   clk, reset (async, active-high)
//   req, we, size, uns, addr, wdata : one request per cycle
//   ready    : initialised, accepting requests
//   ack      : previous-cycle request completed (one-cycle pulse)
//   rdata    : extended load data while ack for a load, else 0
//   addr_err : previous request misaligned or reserved size
//
// state   | meaning
// ST_INIT | clearing word cnt_q each cycle, requests dropped
// ST_RUN  | ready, one request accepted per cycle
module dm_bytemem
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS    = 256,
  parameter int CLEAR_ON_RESET = 1,
  parameter int BIG_ENDIAN     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH_WORDS - 1);

  logic [31:0] mem [DEPTH_WORDS];

  dm_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        ldv_q, ldv_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_uns_q, ld_uns_d;
  logic [31:0] rword_q;

  logic [AW-1:0] req_idx;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata_rep;
  logic          req_misalign;
  logic [31:0]   ld_data;
  logic          accept;
  logic          rd_en;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // Upper address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  assign req_idx = addr[AW+1:2];

  dm_lane #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane (
    .req_size     (size),
    .req_off      (addr[1:0]),
    .req_wdata    (wdata),
    .req_be       (req_be),
    .req_wdata_rep(req_wdata_rep),
    .req_misalign (req_misalign),
    .ld_size      (ld_size_q),
    .ld_off       (ld_off_q),
    .ld_uns       (ld_uns_q),
    .ld_word      (rword_q),
    .ld_data      (ld_data)
  );

  // ready_q gates acceptance, so requests during the sweep are silently dropped.
  assign accept = req & ready_q;
  assign rd_en  = accept & ~we & ~req_misalign;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_idx    = req_idx;
    wr_be     = req_be;
    wr_data   = req_wdata_rep;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_be   = 4'b1111;
      wr_data = 32'h0;
      cnt_d   = cnt_q + AW'(1);
      if (cnt_q == CNT_LAST) state_d = ST_RUN;
    end else begin
      wr_en = accept & we & ~req_misalign;
    end

    ready_d   = (state_d == ST_RUN);
    ack_d     = accept;
    err_d     = accept & req_misalign;
    ldv_d     = rd_en;
    ld_size_d = size;
    ld_off_d  = addr[1:0];
    ld_uns_d  = uns;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ldv_q     <= 1'b0;
      ld_size_q <= SZ_W;
      ld_off_q  <= 2'b00;
      ld_uns_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      ldv_q     <= ldv_d;
      ld_size_q <= ld_size_d;
      ld_off_q  <= ld_off_d;
      ld_uns_q  <= ld_uns_d;
    end
  end

  // Array kept free of reset so it maps onto RAM; contents are cleared by the sweep.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    if (rd_en) rword_q <= mem[req_idx];
  end

  assign ready    = ready_q;
  assign ack      = ack_q;
  assign addr_err = err_q;
  assign rdata    = ldv_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_dm_bytemem.sv
module tb_dm_bytemem;

  localparam int DW = 16;
  localparam int NB = DW * 4;

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  ready;
  logic [1:0]  ack;
  logic [1:0]  addr_err;
  logic [31:0] rdata [2];

  // Instance 0 little-endian, instance 1 big-endian; same stimulus to both.
  dm_bytemem #(.DEPTH_WORDS(DW), .CLEAR_ON_RESET(1), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready[0]), .ack(ack[0]),
    .rdata(rdata[0]), .addr_err(addr_err[0])
  );

  dm_bytemem #(.DEPTH_WORDS(DW), .CLEAR_ON_RESET(1), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready[1]), .ack(ack[1]),
    .rdata(rdata[1]), .addr_err(addr_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int init_cnt = 0;

  // Reference: plain byte array per endianness, byte address modulo NB.
  logic [7:0] mem_b [2][NB];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] mload(input int e, input logic [1:0] sz, input logic u,
                                        input logic [31:0] a);
    int n;
    int ba;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      ba = (int'(a % NB) + k) % NB;
      if (e == 1) v = (v << 8) | {24'h0, mem_b[e][ba]};
      else        v = v | ({24'h0, mem_b[e][ba]} << (8 * k));
    end
    if (n == 1 && !u) v = {{24{v[7]}}, v[7:0]};
    if (n == 2 && !u) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic mstore(input int e, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    int ba;
    logic [31:0] sh;
    n = nbytes(sz);
    for (int k = 0; k < n; k++) begin
      ba = (int'(a % NB) + k) % NB;
      sh = (e == 1) ? d >> (8 * (n - 1 - k)) : d >> (8 * k);
      mem_b[e][ba] = sh[7:0];
    end
  endtask

  task automatic mclear();
    for (int e = 0; e < 2; e++)
      for (int i = 0; i < NB; i++) mem_b[e][i] = 8'h00;
  endtask

  // Drive one cycle of stimulus, then check the response produced by that edge.
  task automatic issue(input logic r, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    logic acc;
    logic mis;
    logic [31:0] exp_rd [2];
    req = r; we = w; size = sz; uns = u; addr = a; wdata = d;
    acc = r && (init_cnt >= DW);
    mis = is_mis(sz, a);
    for (int e = 0; e < 2; e++)
      exp_rd[e] = (acc && !w && !mis) ? mload(e, sz, u, a) : 32'h0;
    if (acc && w && !mis)
      for (int e = 0; e < 2; e++) mstore(e, sz, a, d);
    @(posedge clk);
    #1;
    if (init_cnt < DW) init_cnt++;
    for (int e = 0; e < 2; e++) begin
      chk($sformatf("ack%0d", e),   {31'h0, ack[e]},      {31'h0, acc});
      chk($sformatf("err%0d", e),   {31'h0, addr_err[e]}, {31'h0, acc && mis});
      chk($sformatf("rdata%0d", e), rdata[e],             exp_rd[e]);
      chk($sformatf("ready%0d", e), {31'h0, ready[e]},    {31'h0, init_cnt >= DW});
    end
  endtask

  task automatic idle_until_ready();
    for (int i = 0; i < DW + 2 && init_cnt < DW; i++)
      issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  logic [1:0]  r_sz;
  logic [31:0] r_a;

  initial begin
    reset = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
    mclear();
    #1;
    for (int e = 0; e < 2; e++) begin
      chk("rst_ready", {31'h0, ready[e]}, 32'h0);
      chk("rst_ack",   {31'h0, ack[e]},   32'h0);
      chk("rst_err",   {31'h0, addr_err[e]}, 32'h0);
      chk("rst_rdata", rdata[e], 32'h0);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    init_cnt = 0;

    // Requests during the sweep are dropped; ready rises after exactly DW edges.
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h3C, 32'hCAFEF00D);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    idle_until_ready();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
    chk("init_lw3c", rdata[0], 32'h0);

    // Byte lanes.
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lane_le", rdata[0], 32'h11AA3344);
    chk("lane_be", rdata[1], 32'h1122AA44);

    // Extension.
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000F080);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("lb20", rdata[0], 32'hFFFFFF80);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    chk("lbu20", rdata[0], 32'h00000080);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    chk("lh20", rdata[0], 32'hFFFFF080);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("lhu20", rdata[0], 32'h0000F080);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    chk("lb21", rdata[0], 32'hFFFFFFF0);

    // Misalignment and reserved size: error pulse, no write.
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h23, 32'h0000FFFF);
    issue(1'b1, 1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF);
    chk("mis_err", {31'h0, addr_err[0]}, 32'h1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("mis_nowrite", rdata[0], 32'h0000F080);

    // Back-to-back store then aliased load of the same word.
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h04, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h04 + NB, 32'h0);
    chk("alias_lw", rdata[0], 32'hDEADBEEF);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r_sz = 2'b11;
      else if (r_sz == 2'b11) r_sz = 2'b10;
      r_a = 32'($urandom_range(0, 4 * NB - 1)) | (32'($urandom_range(0, 3)) << 28);
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'b01) r_a[0] = 1'b0;
        if (r_sz == 2'b10) r_a[1:0] = 2'b00;
      end
      issue(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), r_sz,
            1'($urandom_range(0, 1)), r_a, $urandom);
    end

    // Asynchronous reset mid-run.
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h08, 32'h12345678);
    req = 1'b0;
    reset = 1'b1;
    #1;
    for (int e = 0; e < 2; e++) begin
      chk("arst_ack",   {31'h0, ack[e]},   32'h0);
      chk("arst_ready", {31'h0, ready[e]}, 32'h0);
      chk("arst_rdata", rdata[e], 32'h0);
    end
    #1;
    reset = 1'b0;
    mclear();
    init_cnt = 0;
    idle_until_ready();
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    chk("arst_lw08", rdata[0], 32'h0);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
